ct_had_event_xtrig: RTL

- Cluster-level debug cross-trigger hub: the other end of each core's HAD event interface.
- Collects every core's outgoing enter/exit debug requests (x_enter_dbg_req_o / x_exit_dbg_req_o).
- Routes them by destination mask and drives each core's incoming x_enter_dbg_req_i / x_exit_dbg_req_i as clean, stretched levels. The receivers double-flop sample these levels, so every asserted level must span enough cycles to survive that sampling.

---
 rtl/ct_had_event_xtrig_pkg.sv | 13 +
 rtl/ct_had_event_xtrig_if.sv | 27 ++
 rtl/ct_had_event_xtrig_chan.sv | 86 ++++++++
 rtl/ct_had_event_xtrig.sv | 92 +++++++++
 4 files changed

// File: rtl/ct_had_event_xtrig_pkg.sv
// Shared definitions for the cluster debug cross-trigger hub.
// Channel state encodings and counter width.
package ct_had_pkg;

    typedef enum logic [1:0] {
        XTRIG_IDLE = 2'b00,
        XTRIG_HOLD = 2'b01,
        XTRIG_GAP  = 2'b10
    } xtrig_state_e;

    localparam int XTRIG_CNT_W = 4;

endpackage

// File: rtl/ct_had_event_xtrig_if.sv
// Core-facing HAD event bundle of the cross-trigger hub.
// master = core cluster side, slave = hub side.
interface ct_had_event_xtrig_if #(
    parameter int CORE_NUM = 4
);
    logic [CORE_NUM-1:0] x_enter_dbg_req_o;
    logic [CORE_NUM-1:0] x_exit_dbg_req_o;
    logic [CORE_NUM-1:0] core_dbgon;
    logic [CORE_NUM-1:0] x_enter_dbg_req_i;
    logic [CORE_NUM-1:0] x_exit_dbg_req_i;

    modport master (
        output x_enter_dbg_req_o,
        output x_exit_dbg_req_o,
        output core_dbgon,
        input  x_enter_dbg_req_i,
        input  x_exit_dbg_req_i
    );

    modport slave (
        input  x_enter_dbg_req_o,
        input  x_exit_dbg_req_o,
        input  core_dbgon,
        output x_enter_dbg_req_i,
        output x_exit_dbg_req_i
    );
endinterface

// File: rtl/ct_had_event_xtrig_chan.sv
// One routed request channel: stretches a trigger into a fixed-width
// pulse followed by a minimum low gap, collapsing extra triggers into one.
module ct_had_xtrig_chan
    import ct_had_pkg::*;
#(
    parameter int HOLD_CYC = 8,
    parameter int GAP_CYC  = 3
) (
    input  logic forever_cpuclk,
    input  logic cpurst_b,
    input  logic trig,
    input  logic clr_pend,
    input  logic cancel_cond,
    output logic req_out,
    output logic busy
);

    localparam logic [XTRIG_CNT_W-1:0] HOLD_LD = XTRIG_CNT_W'(HOLD_CYC - 1);
    localparam logic [XTRIG_CNT_W-1:0] GAP_LD  = XTRIG_CNT_W'(GAP_CYC - 1);

    xtrig_state_e           state, state_nxt;
    logic [XTRIG_CNT_W-1:0] cnt, cnt_nxt;
    logic                   pend, pend_nxt;
    logic                   pend_eff;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state <= XTRIG_IDLE;
            cnt   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pend  <= pend_nxt;
        end
    end

    assign pend_eff = pend & ~clr_pend;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pend_nxt  = pend_eff;
        unique case (state)
            XTRIG_IDLE: begin
                if (trig) begin
                    state_nxt = XTRIG_HOLD;
                    cnt_nxt   = HOLD_LD;
                end
            end
            XTRIG_HOLD: begin
                if (trig) pend_nxt = 1'b1;
                // Target already reached the requested mode: stop early.
                if (cancel_cond || cnt == '0) begin
                    state_nxt = XTRIG_GAP;
                    cnt_nxt   = GAP_LD;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            XTRIG_GAP: begin
                if (trig) pend_nxt = 1'b1;
                if (cnt == '0) begin
                    pend_nxt = 1'b0;
                    if ((pend_eff || trig) && !cancel_cond) begin
                        state_nxt = XTRIG_HOLD;
                        cnt_nxt   = HOLD_LD;
                    end else begin
                        state_nxt = XTRIG_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = XTRIG_IDLE;
                cnt_nxt   = '0;
                pend_nxt  = 1'b0;
            end
        endcase
    end

    assign req_out = (state == XTRIG_HOLD);
    assign busy    = (state != XTRIG_IDLE) | pend;

endmodule

// File: rtl/ct_had_event_xtrig.sv
// Cluster debug cross-trigger hub: edge-detects core enter/exit requests,
// routes them to other cores and drives stretched request levels back.
module ct_had_event_xtrig
    import ct_had_pkg::*;
#(
    parameter int CORE_NUM = 4,
    parameter int HOLD_CYC = 8,
    parameter int GAP_CYC  = 3
) (
    input  logic                forever_cpuclk,
    input  logic                cpurst_b,
    input  logic                xtrig_en,
    input  logic [CORE_NUM-1:0] enter_dst_mask,
    input  logic [CORE_NUM-1:0] exit_dst_mask,
    ct_had_event_xtrig_if.slave evt,
    output logic                xtrig_busy
);

    logic [CORE_NUM-1:0] enter_hist, exit_hist;
    logic [CORE_NUM-1:0] enter_rise, exit_rise;
    logic [CORE_NUM-1:0] enter_trig, exit_trig;
    logic [CORE_NUM-1:0] enter_acc, exit_acc;
    logic [CORE_NUM-1:0] enter_req, exit_req;
    logic [CORE_NUM-1:0] enter_busy, exit_busy;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            enter_hist <= '0;
            exit_hist  <= '0;
        end else begin
            enter_hist <= evt.x_enter_dbg_req_o;
            exit_hist  <= evt.x_exit_dbg_req_o;
        end
    end

    assign enter_rise = evt.x_enter_dbg_req_o & ~enter_hist;
    assign exit_rise  = evt.x_exit_dbg_req_o & ~exit_hist;

    // A core's own request is never routed back to itself.
    always_comb begin
        enter_trig = '0;
        exit_trig  = '0;
        for (int d = 0; d < CORE_NUM; d++) begin
            for (int s = 0; s < CORE_NUM; s++) begin
                if (s != d) begin
                    enter_trig[d] = enter_trig[d] | enter_rise[s];
                    exit_trig[d]  = exit_trig[d] | exit_rise[s];
                end
            end
            enter_trig[d] = enter_trig[d] & xtrig_en & enter_dst_mask[d];
            exit_trig[d]  = exit_trig[d] & xtrig_en & exit_dst_mask[d];
        end
    end

    // Enter wins a same-cycle collision; each accepted side cancels
    // the other side's pending request.
    assign enter_acc = enter_trig & ~evt.core_dbgon;
    assign exit_acc  = exit_trig & evt.core_dbgon & ~enter_acc;

    for (genvar d = 0; d < CORE_NUM; d++) begin : g_chan
        ct_had_xtrig_chan #(
            .HOLD_CYC (HOLD_CYC),
            .GAP_CYC  (GAP_CYC)
        ) u_enter (
            .forever_cpuclk (forever_cpuclk),
            .cpurst_b       (cpurst_b),
            .trig           (enter_acc[d]),
            .clr_pend       (exit_acc[d]),
            .cancel_cond    (evt.core_dbgon[d]),
            .req_out        (enter_req[d]),
            .busy           (enter_busy[d])
        );

        ct_had_xtrig_chan #(
            .HOLD_CYC (HOLD_CYC),
            .GAP_CYC  (GAP_CYC)
        ) u_exit (
            .forever_cpuclk (forever_cpuclk),
            .cpurst_b       (cpurst_b),
            .trig           (exit_acc[d]),
            .clr_pend       (enter_acc[d]),
            .cancel_cond    (~evt.core_dbgon[d]),
            .req_out        (exit_req[d]),
            .busy           (exit_busy[d])
        );
    end

    assign evt.x_enter_dbg_req_i = enter_req;
    assign evt.x_exit_dbg_req_i  = exit_req;
    assign xtrig_busy            = |{enter_busy, exit_busy};

endmodule
